// File: rtl/dee_merge.sv
// Round-robin merge of the two blockD source streams (dee0/dee1) into one
// FIFO-buffered, source-tagged output stream with per-source accept counters.
module dee_merge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dee0_vld,
  output logic                       dee0_rdy,
  input  logic [DATA_W-1:0]          dee0_data,
  input  logic                       dee1_vld,
  output logic                       dee1_rdy,
  input  logic [DATA_W-1:0]          dee1_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_src,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH) + 1;

  // Counters wrap naturally; clear wins over a coincident increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic clr,
                                                input logic inc);
    if (clr)
      return '0;
    else if (inc)
      return cur + CNT_W'(1);
    else
      return cur;
  endfunction

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FW-1:0]     fill_q;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              full;
  logic              grant;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;

  // Arbitration: contested cycles go to the source not granted last time.
  always_comb begin
    grant = ~last_grant;
    if (dee0_vld && !dee1_vld)
      grant = 1'b0;
    else if (dee1_vld && !dee0_vld)
      grant = 1'b1;
  end

  // Full is from registered occupancy only, so a same-cycle pop never frees a slot.
  assign full      = (fill_q == FW'(DEPTH));
  assign dee0_rdy  = !full && (grant == 1'b0);
  assign dee1_rdy  = !full && (grant == 1'b1);
  assign push      = grant ? (dee1_vld && dee1_rdy) : (dee0_vld && dee0_rdy);
  assign push_data = grant ? dee1_data : dee0_data;
  assign out_vld   = (fill_q != '0);
  assign pop       = out_vld && out_rdy;

  // Storage holds {src, data}; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {grant, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      last_grant <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= grant;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fill_q <= fill_q + FW'(1);
      else if (pop && !push)
        fill_q <= fill_q - FW'(1);
      cnt0_q <= cnt_next(cnt0_q, cnt_clr, push && (grant == 1'b0));
      cnt1_q <= cnt_next(cnt1_q, cnt_clr, push && (grant == 1'b1));
    end
  end

  assign out_data = mem[rd_ptr][DATA_W-1:0];
  assign out_src  = mem[rd_ptr][DATA_W];
  assign fill     = fill_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_dee_merge.sv
// Scoreboard bench for dee_merge: a cycle model predicts handshakes, occupancy
// and counters; accepted words are queued and matched against the FIFO head.
module tb_dee_merge;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              dee0_vld, dee1_vld, out_rdy, cnt_clr;
  logic              dee0_rdy, dee1_rdy, out_vld, out_src;
  logic [DATA_W-1:0] dee0_data, dee1_data, out_data;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic [$clog2(DEPTH):0] fill;

  always #5 clk = ~clk;

  dee_merge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .dee0_vld(dee0_vld), .dee0_rdy(dee0_rdy), .dee0_data(dee0_data),
    .dee1_vld(dee1_vld), .dee1_rdy(dee1_rdy), .dee1_data(dee1_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_src(out_src),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1), .fill(fill)
  );

  int errs = 0;
  int checks = 0;

  logic [DATA_W:0]  sb[$];
  int               fill_m = 0;
  logic             lg_m = 1'b1;
  logic [CNT_W-1:0] c0_m = '0, c1_m = '0;
  logic             mvalid = 1'b0;
  logic             last_push = 1'b0;
  logic             last_src = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: predict and check at negedge, update model at posedge, check state after.
  task automatic cycle();
    logic g, r0, r1, push_m, pop_m;
    logic [DATA_W-1:0] wd;
    g = 1'b0; push_m = 1'b0; pop_m = 1'b0; wd = '0;
    @(negedge clk);
    if (mvalid) begin
      if (dee0_vld && !dee1_vld)      g = 1'b0;
      else if (dee1_vld && !dee0_vld) g = 1'b1;
      else                            g = ~lg_m;
      r0 = (fill_m != DEPTH) && !g;
      r1 = (fill_m != DEPTH) && g;
      if (dee0_vld || dee1_vld) begin
        chk("dee0_rdy", dee0_rdy, r0);
        chk("dee1_rdy", dee1_rdy, r1);
      end
      push_m = g ? (dee1_vld && r1) : (dee0_vld && r0);
      pop_m  = (fill_m != 0) && out_rdy;
      wd     = g ? dee1_data : dee0_data;
      chk("out_vld", out_vld, fill_m != 0);
      if (fill_m != 0) begin
        chk("out_data", out_data, sb[0][DATA_W-1:0]);
        chk("out_src", out_src, sb[0][DATA_W]);
      end
    end
    @(posedge clk);
    last_push = 1'b0;
    if (rst) begin
      sb.delete();
      fill_m = 0; lg_m = 1'b1; c0_m = '0; c1_m = '0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (pop_m) void'(sb.pop_front());
      if (push_m) begin
        sb.push_back({g, wd});
        lg_m = g;
        last_src = g;
      end
      last_push = push_m;
      fill_m = fill_m + int'(push_m) - int'(pop_m);
      if (cnt_clr) begin
        c0_m = '0; c1_m = '0;
      end else if (push_m) begin
        if (g) c1_m = c1_m + 1'b1;
        else   c0_m = c0_m + 1'b1;
      end
    end
    #1;
    if (mvalid) begin
      chk("fill", fill, fill_m);
      chk("cnt0", cnt0, c0_m);
      chk("cnt1", cnt1, c1_m);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    dee0_vld = 1'b0; dee1_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH && fill_m != 0; i++) cycle();
    chk("drain_fill", fill, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; dee0_vld = 1'b0; dee1_vld = 1'b0; out_rdy = 1'b0; cnt_clr = 1'b0;
    dee0_data = '0; dee1_data = '0;
    #1;

    // Reset state
    do_reset();
    chk("rst_fill", fill, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);

    // 1: dee0 sends A, B
    out_rdy = 1'b1; dee0_vld = 1'b1; dee0_data = 32'hAAAA_0001;
    cycle();
    chk("t1_accA", last_push, 1);
    dee0_data = 32'hBBBB_0002;
    cycle();
    dee0_vld = 1'b0;
    cycle();
    cycle();
    chk("t1_cnt0", cnt0, 2);
    chk("t1_cnt1", cnt1, 0);

    // 2: both valid continuously, alternate grants
    do_reset();
    dee0_vld = 1'b1; dee1_vld = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dee0_data = $urandom; dee1_data = $urandom;
      cycle();
      chk("t2_push", last_push, 1);
      chk("t2_grant", last_src, i % 2);
    end
    chk("t2_cnt_eq", cnt0, cnt1);
    drain();

    // 3: back-pressure fills FIFO; pop does not free space same cycle
    out_rdy = 1'b0; dee0_vld = 1'b1; dee0_data = $urandom;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_push) begin n++; dee0_data = $urandom; end
    end
    chk("t3_accepted", n, DEPTH);
    chk("t3_fill", fill, DEPTH);
    chk("t3_rdy0", dee0_rdy, 0);
    chk("t3_rdy1", dee1_rdy, 0);
    out_rdy = 1'b1;
    cycle();
    chk("t3_refused", last_push, 0);
    cycle();
    chk("t3_accept_next", last_push, 1);
    drain();

    // 4: 2*DEPTH+1 words with random back-pressure, pointer wrap
    dee0_vld = 1'b1; dee0_data = $urandom; n = 0;
    for (int i = 0; i < 100 && n < 2 * DEPTH + 1; i++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_push) begin n++; dee0_data = $urandom; end
    end
    chk("t4_accepted", n, 2 * DEPTH + 1);
    drain();

    // 5: counter wrap and clear priority
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    dee1_vld = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dee1_data = $urandom;
      cycle();
    end
    chk("t5_cnt1_wrap", cnt1, 1);
    cnt_clr = 1'b1; dee1_data = $urandom;
    cycle();
    chk("t5_clr_push", last_push, 1);
    chk("t5_cnt1_clr", cnt1, 0);
    cnt_clr = 1'b0;
    drain();

    // 6: reset mid-transfer
    out_rdy = 1'b0; dee0_vld = 1'b1; dee0_data = $urandom;
    for (int i = 0; i < 10 && fill_m < 3; i++) begin
      cycle();
      if (last_push) dee0_data = $urandom;
    end
    chk("t6_fill3", fill, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_out_vld", out_vld, 0);
    chk("t6_fill", fill, 0);
    chk("t6_cnt0", cnt0, 0);
    chk("t6_cnt1", cnt1, 0);
    dee0_vld = 1'b1; dee1_vld = 1'b1; out_rdy = 1'b1;
    dee0_data = $urandom; dee1_data = $urandom;
    cycle();
    chk("t6_first_grant", last_src, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
